// File: rtl/eaglesong_absorb_stream.sv
// Eaglesong absorb front end: packs a byte stream into rate-sized blocks, adds
// delimiter/zero padding and presents each block (and block ^ state) downstream.
module eaglesong_absorb_stream #(
    parameter int          RATE_WORDS = 8,
    parameter int          BEAT_BYTES = 4,
    parameter logic [7:0]  DELIM      = 8'h06
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [8*BEAT_BYTES-1:0]       in_data,
    input  logic [$clog2(BEAT_BYTES+1)-1:0] in_bytes,
    input  logic                          in_last,
    input  logic [32*RATE_WORDS-1:0]      state_in,
    output logic                          blk_valid,
    input  logic                          blk_ready,
    output logic [32*RATE_WORDS-1:0]      blk_data,
    output logic [32*RATE_WORDS-1:0]      state_out,
    output logic                          blk_first,
    output logic                          blk_last,
    output logic [7:0]                    blk_idx
);

    localparam int BLK_BYTES = 4 * RATE_WORDS;
    localparam int BLK_W     = 32 * RATE_WORDS;
    localparam int BIT_W     = $clog2(BLK_W);
    localparam int FILL_W    = (BLK_BYTES > 1) ? $clog2(BLK_BYTES) : 1;

    typedef enum logic [1:0] {
        ST_FILL = 2'd0,
        ST_EMIT = 2'd1,
        ST_PAD  = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [FILL_W-1:0]   fill_q, fill_d;
    logic [BLK_W-1:0]    buf_q, buf_d;
    logic                pad_pending_q, pad_pending_d;
    logic                last_q, last_d;
    logic                first_q, first_d;
    logic [7:0]          idx_q, idx_d;
    logic [31:0]         nb_s;
    logic [31:0]         sum_s;

    // Byte b of the block sits in word b/4, first byte of each word in the MSB.
    function automatic logic [BIT_W-1:0] byte_lsb(input logic [31:0] b);
        logic [31:0] pos;
        pos = ((b >> 2) << 5) + ((32'd3 - (b & 32'd3)) << 3);
        return pos[BIT_W-1:0];
    endfunction

    // State register and datapath flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_FILL;
            fill_q        <= '0;
            buf_q         <= '0;
            pad_pending_q <= 1'b0;
            last_q        <= 1'b0;
            first_q       <= 1'b1;
            idx_q         <= 8'd0;
        end else begin
            state_q       <= state_d;
            fill_q        <= fill_d;
            buf_q         <= buf_d;
            pad_pending_q <= pad_pending_d;
            last_q        <= last_d;
            first_q       <= first_d;
            idx_q         <= idx_d;
        end
    end

    // Next-state and buffer update.
    always_comb begin
        state_d       = state_q;
        fill_d        = fill_q;
        buf_d         = buf_q;
        pad_pending_d = pad_pending_q;
        last_d        = last_q;
        first_d       = first_q;
        idx_d         = idx_q;
        nb_s          = 32'(BEAT_BYTES);
        if (in_last && (32'(in_bytes) < 32'(BEAT_BYTES))) begin
            nb_s = 32'(in_bytes);
        end else begin
            nb_s = 32'(BEAT_BYTES);
        end
        sum_s = 32'(fill_q) + nb_s;
        case (state_q)
            ST_FILL: begin
                if (in_valid) begin
                    // Bytes past in_bytes on a last beat are forced to zero.
                    for (int k = 0; k < BEAT_BYTES; k++) begin
                        buf_d[byte_lsb(32'(fill_q) + 32'(k)) +: 8] =
                            (32'(k) < nb_s) ? in_data[8*k +: 8] : 8'h00;
                    end
                    if (!in_last) begin
                        fill_d = fill_q + FILL_W'(BEAT_BYTES);
                        if (sum_s == 32'(BLK_BYTES)) begin
                            last_d  = 1'b0;
                            state_d = ST_EMIT;
                        end else begin
                            state_d = ST_FILL;
                        end
                    end else if (sum_s < 32'(BLK_BYTES)) begin
                        buf_d[byte_lsb(sum_s) +: 8] = DELIM;
                        last_d  = 1'b1;
                        state_d = ST_EMIT;
                    end else begin
                        // Message ended exactly on a block edge: delimiter needs its own block.
                        last_d        = 1'b0;
                        pad_pending_d = 1'b1;
                        state_d       = ST_EMIT;
                    end
                end else begin
                    state_d = ST_FILL;
                end
            end
            ST_EMIT: begin
                if (blk_ready) begin
                    buf_d  = '0;
                    fill_d = '0;
                    if (pad_pending_q) begin
                        pad_pending_d = 1'b0;
                        buf_d[31:24]  = DELIM;
                        last_d        = 1'b1;
                        first_d       = 1'b0;
                        idx_d         = idx_q + 8'd1;
                        state_d       = ST_PAD;
                    end else if (last_q) begin
                        first_d = 1'b1;
                        idx_d   = 8'd0;
                        state_d = ST_FILL;
                    end else begin
                        first_d = 1'b0;
                        idx_d   = idx_q + 8'd1;
                        state_d = ST_FILL;
                    end
                end else begin
                    state_d = ST_EMIT;
                end
            end
            ST_PAD: begin
                if (blk_ready) begin
                    buf_d   = '0;
                    fill_d  = '0;
                    last_d  = 1'b0;
                    first_d = 1'b1;
                    idx_d   = 8'd0;
                    state_d = ST_FILL;
                end else begin
                    state_d = ST_PAD;
                end
            end
            default: begin
                state_d       = ST_FILL;
                fill_d        = '0;
                buf_d         = '0;
                pad_pending_d = 1'b0;
                last_d        = 1'b0;
                first_d       = 1'b1;
                idx_d         = 8'd0;
            end
        endcase
    end

    // Outputs decoded from registered state only (no blk_ready feed-through).
    always_comb begin
        case (state_q)
            ST_FILL: begin
                in_ready  = 1'b1;
                blk_valid = 1'b0;
            end
            ST_EMIT, ST_PAD: begin
                in_ready  = 1'b0;
                blk_valid = 1'b1;
            end
            default: begin
                in_ready  = 1'b0;
                blk_valid = 1'b0;
            end
        endcase
        blk_data  = buf_q;
        blk_first = first_q;
        blk_last  = last_q;
        blk_idx   = idx_q;
        if (first_q) begin
            state_out = buf_q;
        end else begin
            state_out = buf_q ^ state_in;
        end
    end

endmodule

// File: tb/tb_eaglesong_absorb_stream.sv
// Directed bench for eaglesong_absorb_stream: default geometry plus a
// BEAT_BYTES=1 / RATE_WORDS=2 instance.
module tb_eaglesong_absorb_stream;

    logic         clk = 1'b0;
    logic         rst_n;
    always #5 clk = ~clk;

    logic         in_valid, in_ready, in_last, blk_valid, blk_ready, blk_first, blk_last;
    logic [31:0]  in_data;
    logic [2:0]   in_bytes;
    logic [255:0] state_in, blk_data, state_out;
    logic [7:0]   blk_idx;

    logic         b_in_valid, b_in_ready, b_in_last, b_blk_valid, b_blk_ready, b_blk_first, b_blk_last;
    logic [7:0]   b_in_data;
    logic [0:0]   b_in_bytes;
    logic [63:0]  b_state_in, b_blk_data, b_state_out;
    logic [7:0]   b_blk_idx;

    int n_vec = 0;
    int n_err = 0;

    eaglesong_absorb_stream dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_bytes(in_bytes), .in_last(in_last), .state_in(state_in),
        .blk_valid(blk_valid), .blk_ready(blk_ready), .blk_data(blk_data),
        .state_out(state_out), .blk_first(blk_first), .blk_last(blk_last), .blk_idx(blk_idx)
    );

    eaglesong_absorb_stream #(.RATE_WORDS(2), .BEAT_BYTES(1), .DELIM(8'h06)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_data(b_in_data), .in_bytes(b_in_bytes), .in_last(b_in_last), .state_in(b_state_in),
        .blk_valid(b_blk_valid), .blk_ready(b_blk_ready), .blk_data(b_blk_data),
        .state_out(b_state_out), .blk_first(b_blk_first), .blk_last(b_blk_last), .blk_idx(b_blk_idx)
    );

    task automatic check_val(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [31:0] d, input logic [2:0] nb, input logic last);
        int t = 0;
        @(negedge clk);
        while (!in_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) check_val("tmo_in_ready", 256'(in_ready), 256'(1'b1));
        in_valid = 1'b1; in_data = d; in_bytes = nb; in_last = last;
        @(posedge clk);
        #1;
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic check_blk(input string tag, input logic [255:0] ed, input logic [255:0] eso,
                             input logic ef, input logic el, input logic [7:0] ei);
        int t = 0;
        @(negedge clk);
        while (!blk_valid && t < 100) begin
            @(negedge clk);
            t++;
        end
        check_val({tag, "_valid"}, 256'(blk_valid), 256'(1'b1));
        check_val({tag, "_data"},  blk_data, ed);
        check_val({tag, "_sout"},  state_out, eso);
        check_val({tag, "_first"}, 256'(blk_first), 256'(ef));
        check_val({tag, "_last"},  256'(blk_last), 256'(el));
        check_val({tag, "_idx"},   256'(blk_idx), 256'(ei));
        blk_ready = 1'b1;
        @(posedge clk);
        #1;
        blk_ready = 1'b0;
    endtask

    task automatic send_b(input logic [7:0] d, input logic last);
        int t = 0;
        @(negedge clk);
        while (!b_in_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!b_in_ready) check_val("tmo_b_in_ready", 256'(b_in_ready), 256'(1'b1));
        b_in_valid = 1'b1; b_in_data = d; b_in_bytes = 1'b1; b_in_last = last;
        @(posedge clk);
        #1;
        b_in_valid = 1'b0; b_in_last = 1'b0;
    endtask

    task automatic check_blk_b(input string tag, input logic [63:0] ed, input logic [63:0] eso,
                               input logic ef, input logic el, input logic [7:0] ei);
        int t = 0;
        @(negedge clk);
        while (!b_blk_valid && t < 100) begin
            @(negedge clk);
            t++;
        end
        check_val({tag, "_valid"}, 256'(b_blk_valid), 256'(1'b1));
        check_val({tag, "_data"},  256'(b_blk_data), 256'(ed));
        check_val({tag, "_sout"},  256'(b_state_out), 256'(eso));
        check_val({tag, "_first"}, 256'(b_blk_first), 256'(ef));
        check_val({tag, "_last"},  256'(b_blk_last), 256'(el));
        check_val({tag, "_idx"},   256'(b_blk_idx), 256'(ei));
        b_blk_ready = 1'b1;
        @(posedge clk);
        #1;
        b_blk_ready = 1'b0;
    endtask

    logic [255:0] exp_blk;
    logic [255:0] abc_blk;

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0; in_data = '0; in_bytes = '0; in_last = 1'b0; blk_ready = 1'b0;
        state_in = {8{32'h12345678}};
        b_in_valid = 1'b0; b_in_data = '0; b_in_bytes = '0; b_in_last = 1'b0; b_blk_ready = 1'b0;
        b_state_in = '0;
        abc_blk = 256'h61626306;
        #12;
        check_val("rst_in_ready",  256'(in_ready), 256'(1'b1));
        check_val("rst_blk_valid", 256'(blk_valid), 256'(1'b0));
        check_val("rst_blk_data",  blk_data, 256'h0);
        check_val("rst_state_out", state_out, 256'h0);
        check_val("rst_first",     256'(blk_first), 256'(1'b1));
        check_val("rst_last",      256'(blk_last), 256'(1'b0));
        check_val("rst_idx",       256'(blk_idx), 256'(8'd0));
        @(negedge clk);
        rst_n = 1'b1;

        // Zero-length message
        send(32'hDEADBEEF, 3'd0, 1'b1);
        check_blk("zero", 256'h06000000, 256'h06000000, 1'b1, 1'b1, 8'd0);

        // "abc" with garbage in the unused byte, plus one-cycle latency check
        send(32'hFF636261, 3'd3, 1'b1);
        @(negedge clk);
        check_val("abc_latency", 256'(blk_valid), 256'(1'b1));
        check_blk("abc", abc_blk, abc_blk, 1'b1, 1'b1, 8'd0);

        // Exactly 32 bytes: data block then PAD block; in_bytes ignored on non-last beats
        state_in = {8{32'hA5A5A5A5}};
        for (int k = 0; k < 8; k++) begin
            send({8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)}, (k == 7) ? 3'd4 : 3'd1, k == 7);
            exp_blk[32*k +: 32] = {8'(4*k), 8'(4*k+1), 8'(4*k+2), 8'(4*k+3)};
        end
        check_val("b32_w0", 256'(exp_blk[31:0]), 256'(32'h00010203));
        check_blk("b32_data", exp_blk, exp_blk, 1'b1, 1'b0, 8'd0);
        check_blk("b32_pad", 256'h06000000, {{7{32'hA5A5A5A5}}, 32'hA3A5A5A5}, 1'b0, 1'b1, 8'd1);

        // Backpressure: full block held for 10 cycles with in_valid asserted
        state_in = '0;
        for (int k = 0; k < 8; k++) begin
            send({8'(4*k+35), 8'(4*k+34), 8'(4*k+33), 8'(4*k+32)}, 3'd0, 1'b0);
            exp_blk[32*k +: 32] = {8'(4*k+32), 8'(4*k+33), 8'(4*k+34), 8'(4*k+35)};
        end
        in_valid = 1'b1; in_data = 32'hCAFEBABE; in_bytes = 3'd4; in_last = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check_val("bp_valid", 256'(blk_valid), 256'(1'b1));
            check_val("bp_in_ready", 256'(in_ready), 256'(1'b0));
            check_val("bp_data", blk_data, exp_blk);
        end
        in_valid = 1'b0; in_last = 1'b0;
        check_blk("bp_blk", exp_blk, exp_blk, 1'b1, 1'b0, 8'd0);
        @(negedge clk);
        check_val("bp_in_ready_after", 256'(in_ready), 256'(1'b1));
        check_val("bp_valid_after", 256'(blk_valid), 256'(1'b0));
        send(32'h00636261, 3'd3, 1'b1);
        check_blk("bp_tail", abc_blk, abc_blk, 1'b0, 1'b1, 8'd1);

        // Reset mid-message discards the partial block
        for (int k = 0; k < 5; k++) send(32'h11223344, 3'd4, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_val("mrst_valid", 256'(blk_valid), 256'(1'b0));
        check_val("mrst_data", blk_data, 256'h0);
        @(negedge clk);
        rst_n = 1'b1;
        send(32'hFF636261, 3'd3, 1'b1);
        check_blk("mrst_abc", abc_blk, abc_blk, 1'b1, 1'b1, 8'd0);

        // Narrow instance: 7 bytes, then 8 bytes with PAD block
        b_state_in = {32'h11111111, 32'h22222222};
        for (int k = 0; k < 7; k++) send_b(8'(k + 1), k == 6);
        check_blk_b("n7", {32'h05060706, 32'h01020304}, {32'h05060706, 32'h01020304}, 1'b1, 1'b1, 8'd0);
        for (int k = 0; k < 8; k++) send_b(8'(k + 1), k == 7);
        check_blk_b("n8_data", {32'h05060708, 32'h01020304}, {32'h05060708, 32'h01020304}, 1'b1, 1'b0, 8'd0);
        check_blk_b("n8_pad", {32'h00000000, 32'h06000000}, {32'h11111111, 32'h24222222}, 1'b0, 1'b1, 8'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
